axi4lite_cmd_master: RTL and testbench
======================================

# axi4lite_cmd_master

Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command port into AXI4-Lite write and read transactions. It sits between the control/sequencer logic and the AXI4-Lite register slaves of the music-box datapath. Its typical use is writing the global-reset register and polling the BRAM read/write address registers, without a PS-side master. It returns the read data and BRESP/RRESP on a response port.

## Interface
Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
- C_M_AXI_ADDR_WIDTH, 4, AXI address width.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with the timeout feature.

Ports:
- axi4lite_ext_aclk  in  1  sole clock.
- axi4lite_ext_aresetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- rsp_timeout  out  1  response was synthesised by the watchdog.
- axi4lite_m_awaddr/awprot/awvalid/awready  AXI AW channel; awprot tied to 3'b000.
- axi4lite_m_wdata/wstrb/wvalid/wready  AXI W channel.
- axi4lite_m_bresp/bvalid/bready  AXI B channel.
- axi4lite_m_araddr/arprot/arvalid/arready  AXI AR channel; arprot tied to 3'b000.
- axi4lite_m_rdata/rresp/rvalid/rready  AXI R channel.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready=1.
  - On a cmd handshake: latch addr, wdata and wstrb.
  - Go to WR_REQ if cmd_write, else RD_REQ.
- WR_REQ:
  - Assert awvalid and wvalid together, from the same cycle.
  - Each channel drops its own valid after its handshake.
  - Move to WR_RESP once both handshakes have completed, whether in the same cycle or in different cycles.
  - Address and data stay stable while their valid is high.
- WR_RESP:
  - bready=1.
  - On bvalid: capture bresp, set rdata to 0, go to RSP.
- RD_REQ: assert arvalid until arready, then go to RD_RESP.
- RD_RESP:
  - rready=1.
  - On rvalid: capture rdata and rresp, go to RSP.
- RSP:
  - rsp_valid=1 with registered data.
  - On rsp_ready, return to IDLE.
- Only one transaction is outstanding at a time. cmd_ready=0 in every state except IDLE.
- A response with bvalid or rvalid while in a request state is not expected. If one arrives, it is ignored; bready and rready are low there.
- Reset mid-transaction:
  - All valids, readies and rsp_valid clear immediately.
  - The FSM returns to IDLE.
  - The slave is not drained.

## Timing
- Reset values:
  - cmd_ready=0 during reset; 1 from the first clock edge after release.
  - All AXI valid and ready outputs are 0.
  - All AXI address and data outputs are 0.
  - rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0.
- All outputs are registered. cmd_ready is the exception: it is decoded from the state.
- Cycle timing from command handshake at cycle 0:
  - awvalid, wvalid or arvalid go high at cycle 1.
  - With a zero-wait slave (ready and response each arriving the cycle after valid), rsp_valid is high at cycle 4.
- Back-to-back operation: the next command can be accepted 1 cycle after the rsp handshake.

## Configuration
- AXI4LITE_CMD_MASTER_TIMEOUT_EN defined:
  - A counter is cleared on entry to each request state. It counts every cycle spent in WR_REQ, WR_RESP, RD_REQ or RD_RESP.
  - When the count reaches TIMEOUT_CYCLES-1, the block drops all AXI valids and readies.
  - It then enters RSP with rsp_resp=2'b10 (SLVERR), rsp_timeout=1 and rsp_rdata=0.
  - A late AXI response after a timeout is not accepted.
- Not defined: no counter is built, rsp_timeout is tied to 0, and the block waits indefinitely.

## Structure
- Shared package axi4lite_pkg:
  - state enum;
  - response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - protection constant PROT_DEFAULT=3'b000.
- No sub-module; the watchdog stays inline under the macro.

## Test plan
- Write 0x00000001 with wstrb 4'hF to addr 0x8, zero-wait slave.
  - Expected: awvalid and wvalid rise at cycle 1, awaddr=0x8, wdata=0x1.
  - Expected: rsp_valid at cycle 4, rsp_resp=0, rsp_rdata=0.
- Slave accepts W 3 cycles before AW.
  - Expected: wvalid drops after the W handshake, awvalid holds until the AW handshake.
  - Expected: exactly one B is consumed.
- Read addr 0x0, slave returns 0x000003FF after 5 wait cycles.
  - Expected: rsp_rdata=0x3FF, rsp_resp=0, rready held high throughout.
- rsp_ready held low for 10 cycles.
  - Expected: rsp fields stay stable, cmd_ready=0, no new AXI traffic; new command accepted the cycle after the rsp handshake.
- axi4lite_ext_aresetn pulsed low while arvalid=1.
  - Expected: arvalid=0 and rsp_valid=0 asynchronously; cmd_ready=1 on the first edge after release.
- With AXI4LITE_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts bvalid.
  - Expected: rsp_valid with rsp_resp=2'b10 and rsp_timeout=1 after 16 cycles in WR_REQ/WR_RESP combined.
  - Expected: a late bvalid is ignored.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
//   state_e      : transaction FSM states
//   RESP_*       : AXI4-Lite response codes
//   PROT_DEFAULT : AxPROT value driven on AW and AR
package axi4lite_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StRsp
  } state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator. Converts a valid/ready command port into one AXI4-Lite
// write (AW+W, then B) or read (AR, then R) and returns read data and BRESP/RRESP on a
// valid/ready response port.
//
// Ports:
//   axi4lite_ext_aclk / axi4lite_ext_aresetn : clock, asynchronous active-low reset
//   cmd_*                                    : command in (write flag, address, data, strobes)
//   rsp_*                                    : response out (read data, resp code, timeout flag)
//   axi4lite_m_*                             : AXI4-Lite master channels AW, W, B, AR, R
//
// Build option: define AXI4LITE_CMD_MASTER_TIMEOUT_EN to add a watchdog that abandons a
// transaction after TIMEOUT_CYCLES busy cycles and answers with SLVERR and rsp_timeout=1.
// Without it rsp_timeout is tied low and the block waits indefinitely.
module axi4lite_cmd_master
  import axi4lite_pkg::*;
#(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic                              axi4lite_ext_aclk,
  input  logic                              axi4lite_ext_aresetn,
  // Command port
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // Response port
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  // AXI4-Lite AW
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     axi4lite_m_awaddr,
  output logic [2:0]                        axi4lite_m_awprot,
  output logic                              axi4lite_m_awvalid,
  input  logic                              axi4lite_m_awready,
  // AXI4-Lite W
  output logic [C_M_AXI_DATA_WIDTH-1:0]     axi4lite_m_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   axi4lite_m_wstrb,
  output logic                              axi4lite_m_wvalid,
  input  logic                              axi4lite_m_wready,
  // AXI4-Lite B
  input  logic [1:0]                        axi4lite_m_bresp,
  input  logic                              axi4lite_m_bvalid,
  output logic                              axi4lite_m_bready,
  // AXI4-Lite AR
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     axi4lite_m_araddr,
  output logic [2:0]                        axi4lite_m_arprot,
  output logic                              axi4lite_m_arvalid,
  input  logic                              axi4lite_m_arready,
  // AXI4-Lite R
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     axi4lite_m_rdata,
  input  logic [1:0]                        axi4lite_m_rresp,
  input  logic                              axi4lite_m_rvalid,
  output logic                              axi4lite_m_rready
);

  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;

  state_e          state_d, state_q;
  logic            init_q;
  logic [AW-1:0]   awaddr_d, awaddr_q;
  logic            awvalid_d, awvalid_q;
  logic [DW-1:0]   wdata_d, wdata_q;
  logic [SW-1:0]   wstrb_d, wstrb_q;
  logic            wvalid_d, wvalid_q;
  logic            bready_d, bready_q;
  logic [AW-1:0]   araddr_d, araddr_q;
  logic            arvalid_d, arvalid_q;
  logic            rready_d, rready_q;
  logic            rsp_valid_d, rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_d, rsp_rdata_q;
  logic [1:0]      rsp_resp_d, rsp_resp_q;

`ifdef AXI4LITE_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            rsp_timeout_d, rsp_timeout_q;
`endif

  // cmd_ready must stay low while reset is held even though the state register sits in StIdle.
  assign cmd_ready = init_q && (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXI4LITE_CMD_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrReq;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = StRdReq;
          end
        end
      end
      StWrReq: begin
        // AW and W complete independently; leave once neither is still pending.
        awvalid_d = awvalid_q && !axi4lite_m_awready;
        wvalid_d  = wvalid_q && !axi4lite_m_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = StWrResp;
        end
      end
      StWrResp: begin
        if (axi4lite_m_bvalid) begin
          bready_d    = 1'b0;
          rsp_resp_d  = axi4lite_m_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
        end
      end
      StRdReq: begin
        if (axi4lite_m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdResp;
        end
      end
      StRdResp: begin
        if (axi4lite_m_rvalid) begin
          rready_d    = 1'b0;
          rsp_resp_d  = axi4lite_m_rresp;
          rsp_rdata_d = axi4lite_m_rdata;
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef AXI4LITE_CMD_MASTER_TIMEOUT_EN
    if (state_q == StIdle) begin
      cnt_d = '0;
    end
    if (state_q == StRsp && rsp_ready) begin
      rsp_timeout_d = 1'b0;
    end
    // A genuine response arriving on the last allowed cycle still wins over the watchdog.
    if ((state_q inside {StWrReq, StWrResp, StRdReq, StRdResp}) && (state_d != StRsp)) begin
      if (cnt_q == CntLast) begin
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_resp_d    = RESP_SLVERR;
        rsp_rdata_d   = '0;
        rsp_timeout_d = 1'b1;
        state_d       = StRsp;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge axi4lite_ext_aclk or negedge axi4lite_ext_aresetn) begin
    if (!axi4lite_ext_aresetn) begin
      state_q     <= StIdle;
      init_q      <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      init_q      <= 1'b1;  // marks the first edge after reset release
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXI4LITE_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge axi4lite_ext_aclk or negedge axi4lite_ext_aresetn) begin
    if (!axi4lite_ext_aresetn) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, RESP_SLVERR};
  assign rsp_timeout        = 1'b0;
`endif

  assign axi4lite_m_awaddr  = awaddr_q;
  assign axi4lite_m_awprot  = PROT_DEFAULT;
  assign axi4lite_m_awvalid = awvalid_q;
  assign axi4lite_m_wdata   = wdata_q;
  assign axi4lite_m_wstrb   = wstrb_q;
  assign axi4lite_m_wvalid  = wvalid_q;
  assign axi4lite_m_bready  = bready_q;
  assign axi4lite_m_araddr  = araddr_q;
  assign axi4lite_m_arprot  = PROT_DEFAULT;
  assign axi4lite_m_arvalid = arvalid_q;
  assign axi4lite_m_rready  = rready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_resp           = rsp_resp_q;

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Self-checking bench for axi4lite_cmd_master: behavioural AXI4-Lite slave with configurable wait
// states, a handshake monitor, and per-scenario tasks comparing against expectations derived from
// the command and the slave configuration.
module tb_axi4lite_cmd_master;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  axi4lite_cmd_master #(
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_WIDTH (4),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .axi4lite_ext_aclk    (clk),
    .axi4lite_ext_aresetn (rst_n),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_write            (cmd_write),
    .cmd_addr             (cmd_addr),
    .cmd_wdata            (cmd_wdata),
    .cmd_wstrb            (cmd_wstrb),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_rdata            (rsp_rdata),
    .rsp_resp             (rsp_resp),
    .rsp_timeout          (rsp_timeout),
    .axi4lite_m_awaddr    (awaddr),
    .axi4lite_m_awprot    (awprot),
    .axi4lite_m_awvalid   (awvalid),
    .axi4lite_m_awready   (awready),
    .axi4lite_m_wdata     (wdata),
    .axi4lite_m_wstrb     (wstrb),
    .axi4lite_m_wvalid    (wvalid),
    .axi4lite_m_wready    (wready),
    .axi4lite_m_bresp     (bresp),
    .axi4lite_m_bvalid    (bvalid),
    .axi4lite_m_bready    (bready),
    .axi4lite_m_araddr    (araddr),
    .axi4lite_m_arprot    (arprot),
    .axi4lite_m_arvalid   (arvalid),
    .axi4lite_m_arready   (arready),
    .axi4lite_m_rdata     (rdata),
    .axi4lite_m_rresp     (rresp),
    .axi4lite_m_rvalid    (rvalid),
    .axi4lite_m_rready    (rready)
  );

  // Slave configuration: wait cycles before each ready/response, response contents.
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit          b_en = 1'b1;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;

  // Behavioural slave.
  logic aw_got, w_got, ar_got;
  int   aw_wait, w_wait, b_wait, ar_wait, r_wait;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; arready <= 1'b0; rvalid <= 1'b0;
      bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
    end else begin
      if (awready) awready <= 1'b0;
      else if (awvalid) begin
        if (aw_wait >= aw_delay) begin awready <= 1'b1; aw_wait <= 0; end
        else aw_wait <= aw_wait + 1;
      end
      if (wready) wready <= 1'b0;
      else if (wvalid) begin
        if (w_wait >= w_delay) begin wready <= 1'b1; w_wait <= 0; end
        else w_wait <= w_wait + 1;
      end
      if (arready) arready <= 1'b0;
      else if (arvalid) begin
        if (ar_wait >= ar_delay) begin arready <= 1'b1; ar_wait <= 0; end
        else ar_wait <= ar_wait + 1;
      end
      if (bvalid) begin
        if (bready) bvalid <= 1'b0;
      end else if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && b_en) begin
        if (b_wait >= b_delay) begin
          bvalid <= 1'b1; bresp <= b_resp_cfg; aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
        end else begin
          b_wait <= b_wait + 1; aw_got <= 1'b1; w_got <= 1'b1;
        end
      end else begin
        if (awvalid && awready) aw_got <= 1'b1;
        if (wvalid && wready) w_got <= 1'b1;
      end
      if (rvalid) begin
        if (rready) rvalid <= 1'b0;
      end else if (ar_got || (arvalid && arready)) begin
        if (r_wait >= r_delay) begin
          rvalid <= 1'b1; rdata <= r_data_cfg; rresp <= r_resp_cfg; ar_got <= 1'b0; r_wait <= 0;
        end else begin
          r_wait <= r_wait + 1; ar_got <= 1'b1;
        end
      end
    end
  end

  // Handshake monitor.
  int          aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  logic [3:0]  cap_awaddr = '0, cap_araddr = '0, cap_wstrb = '0;
  logic [31:0] cap_wdata = '0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (awvalid && awready) begin aw_n <= aw_n + 1; cap_awaddr <= awaddr; end
      if (wvalid && wready) begin w_n <= w_n + 1; cap_wdata <= wdata; cap_wstrb <= wstrb; end
      if (bvalid && bready) b_n <= b_n + 1;
      if (arvalid && arready) begin ar_n <= ar_n + 1; cap_araddr <= araddr; end
      if (rvalid && rready) r_n <= r_n + 1;
    end
  end

  // Present a command at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      else waited++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  // k counts cycles after the accepting edge (k=1 is the first cycle of the transaction).
  task automatic wait_rsp(input int k0, output int k);
    k = k0;
    while (!rsp_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic rsp_handshake(input int hold);
    for (int i = 0; i < hold; i++) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready);
    end
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_handshakes got %b want 0",
                         {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    checks++;
    if ({awaddr, araddr, wdata, wstrb, awprot, arprot} !== 50'b0) begin
      errors++; $display("FAIL reset_addr_data got %h want 0",
                         {awaddr, araddr, wdata, wstrb, awprot, arprot});
    end
    checks++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'b0) begin
      errors++; $display("FAIL reset_rsp got %h want 0", {rsp_rdata, rsp_resp, rsp_timeout});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL release_no_edge_cmd_ready got %b want 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL release_first_edge_cmd_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    bit ok; int waited, k, b0;
    aw_delay = 0; w_delay = 0; b_delay = 0; b_resp_cfg = 2'b00;
    b0 = b_n;
    issue(1'b1, 4'h8, 32'h0000_0001, 4'hF, ok, waited);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr0_accept got 0 want 1"); end
    checks++;
    if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {2'b11, 4'h8, 32'h1, 4'hF}) begin
      errors++; $display("FAIL wr0_cycle1 got %h want %h", {awvalid, wvalid, awaddr, wdata, wstrb},
                         {2'b11, 4'h8, 32'h1, 4'hF});
    end
    wait_rsp(1, k);
    checks++;
    if (k !== 4) begin errors++; $display("FAIL wr0_latency got %0d want 4", k); end
    checks++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'b0) begin
      errors++; $display("FAIL wr0_rsp got %h want 0", {rsp_rdata, rsp_resp, rsp_timeout});
    end
    rsp_handshake(0);
    checks++;
    if (b_n - b0 !== 1) begin errors++; $display("FAIL wr0_b_count got %0d want 1", b_n - b0); end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr0_cmd_ready_after got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_w_before_aw();
    bit ok; int waited, k, aw0, w0, b0;
    logic [31:0] d;
    d = $urandom;
    aw_delay = 3; w_delay = 0; b_delay = 0; b_resp_cfg = 2'b00;
    aw0 = aw_n; w0 = w_n; b0 = b_n;
    issue(1'b1, 4'h4, d, 4'h3, ok, waited);
    @(negedge clk);  // k=2
    @(negedge clk);  // k=3: W done, AW still pending
    checks++;
    if ({awvalid, wvalid} !== 2'b10) begin
      errors++; $display("FAIL wfirst_k3 got %b want 10", {awvalid, wvalid});
    end
    @(negedge clk);
    @(negedge clk);  // k=5
    checks++;
    if ({awvalid, wvalid, awaddr} !== {2'b10, 4'h4}) begin
      errors++; $display("FAIL wfirst_k5 got %h want %h", {awvalid, wvalid, awaddr}, {2'b10, 4'h4});
    end
    @(negedge clk);  // k=6
    checks++;
    if ({awvalid, wvalid} !== 2'b00) begin
      errors++; $display("FAIL wfirst_k6 got %b want 00", {awvalid, wvalid});
    end
    wait_rsp(6, k);
    checks++;
    if (k !== 7) begin errors++; $display("FAIL wfirst_latency got %0d want 7", k); end
    rsp_handshake(2);
    repeat (3) @(negedge clk);
    checks++;
    if ({aw_n - aw0, w_n - w0, b_n - b0} !== {32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL wfirst_counts got %0d/%0d/%0d want 1/1/1",
                         aw_n - aw0, w_n - w0, b_n - b0);
    end
    checks++;
    if (cap_wdata !== d) begin
      errors++; $display("FAIL wfirst_wdata got %h want %h", cap_wdata, d);
    end
    aw_delay = 0;
  endtask

  task automatic test_read_wait();
    bit ok, bad; int waited, k;
    ar_delay = 0; r_delay = 5; r_data_cfg = 32'h0000_03FF; r_resp_cfg = 2'b00;
    issue(1'b0, 4'h0, 32'h0, 4'h0, ok, waited);
    checks++;
    if ({arvalid, araddr} !== {1'b1, 4'h0}) begin
      errors++; $display("FAIL rd_cycle1 got %h want %h", {arvalid, araddr}, {1'b1, 4'h0});
    end
    k = 1; bad = 1'b0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
      if (!rsp_valid && k >= 3 && rready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (k !== 9) begin errors++; $display("FAIL rd_latency got %0d want 9", k); end
    checks++;
    if (bad) begin errors++; $display("FAIL rd_rready_held got dropped want held"); end
    checks++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== {32'h3FF, 2'b00, 1'b0}) begin
      errors++; $display("FAIL rd_rsp got %h want %h", {rsp_rdata, rsp_resp, rsp_timeout},
                         {32'h3FF, 2'b00, 1'b0});
    end
    rsp_handshake(0);
    r_delay = 0;
  endtask

  task automatic test_rsp_backpressure();
    bit ok, bad; int waited, k, aw0, ar0;
    logic [31:0] d;
    logic [34:0] held;
    d = $urandom;
    aw_delay = 0; w_delay = 0; b_delay = 0; b_resp_cfg = 2'b10;
    issue(1'b1, 4'hC, d, 4'h5, ok, waited);
    wait_rsp(1, k);
    held = {rsp_rdata, rsp_resp, rsp_timeout};
    checks++;
    if (held !== {32'h0, 2'b10, 1'b0}) begin
      errors++; $display("FAIL bp_rsp got %h want %h", held, {32'h0, 2'b10, 1'b0});
    end
    aw0 = aw_n; ar0 = ar_n; bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || {rsp_rdata, rsp_resp, rsp_timeout} !== held || cmd_ready !== 1'b0 ||
          {awvalid, wvalid, arvalid, bready, rready} !== 5'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL bp_stable got changed want stable"); end
    checks++;
    if ({aw_n - aw0, ar_n - ar0} !== 64'b0) begin
      errors++; $display("FAIL bp_traffic got %0d/%0d want 0/0", aw_n - aw0, ar_n - ar0);
    end
    // Next command is already waiting when the response is consumed.
    ar_delay = 0; r_delay = 0; r_data_cfg = $urandom; r_resp_cfg = 2'b01;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(1'b0, 4'h2, 32'h0, 4'h0, ok, waited);
    checks++;
    if (!ok || waited !== 0) begin
      errors++; $display("FAIL b2b_accept got ok=%0d waited=%0d want ok=1 waited=0", ok, waited);
    end
    wait_rsp(1, k);
    checks++;
    if ({k[7:0], rsp_rdata, rsp_resp} !== {8'd4, r_data_cfg, 2'b01}) begin
      errors++; $display("FAIL b2b_rsp got %h want %h", {k[7:0], rsp_rdata, rsp_resp},
                         {8'd4, r_data_cfg, 2'b01});
    end
    rsp_handshake(0);
  endtask

  task automatic test_reset_mid();
    bit ok; int waited, ar0;
    ar_delay = 20;
    ar0 = ar_n;
    issue(1'b0, 4'hA, 32'h0, 4'h0, ok, waited);
    checks++;
    if ({arvalid, araddr} !== {1'b1, 4'hA}) begin
      errors++; $display("FAIL rstmid_arvalid got %h want %h", {arvalid, araddr}, {1'b1, 4'hA});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({arvalid, rsp_valid, cmd_ready, rready, araddr} !== 8'b0) begin
      errors++; $display("FAIL rstmid_async got %h want 0",
                         {arvalid, rsp_valid, cmd_ready, rready, araddr});
    end
    @(negedge clk);
    ar_delay = 0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_release got %b want 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if ({cmd_ready, arvalid} !== 2'b10) begin
      errors++; $display("FAIL rstmid_first_edge got %b want 10", {cmd_ready, arvalid});
    end
    checks++;
    if (ar_n !== ar0) begin errors++; $display("FAIL rstmid_no_ar got %0d want %0d", ar_n, ar0); end
  endtask

  task automatic test_random();
    bit ok; int waited, k, exp_lat, aw0, w0, b0, ar0, r0;
    logic w; logic [3:0] a, s; logic [31:0] d;
    logic [34:0] exp_rsp;
    for (int n = 0; n < 24; n++) begin
      w = 1'($urandom); a = 4'($urandom); s = 4'($urandom); d = $urandom;
      aw_delay = $urandom_range(0, 4); w_delay = $urandom_range(0, 4);
      b_delay = $urandom_range(0, 4); ar_delay = $urandom_range(0, 4);
      r_delay = $urandom_range(0, 4);
      b_resp_cfg = 2'($urandom); r_resp_cfg = 2'($urandom); r_data_cfg = $urandom;
      exp_lat = w ? 4 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay
                  : 4 + ar_delay + r_delay;
      exp_rsp = w ? {32'h0, b_resp_cfg, 1'b0} : {r_data_cfg, r_resp_cfg, 1'b0};
      aw0 = aw_n; w0 = w_n; b0 = b_n; ar0 = ar_n; r0 = r_n;
      issue(w, a, d, s, ok, waited);
      wait_rsp(1, k);
      checks++;
      if (k !== exp_lat) begin
        errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, k, exp_lat);
      end
      checks++;
      if ({rsp_rdata, rsp_resp, rsp_timeout} !== exp_rsp) begin
        errors++; $display("FAIL rand%0d_rsp got %h want %h", n,
                           {rsp_rdata, rsp_resp, rsp_timeout}, exp_rsp);
      end
      checks++;
      if (w && {cap_awaddr, cap_wdata, cap_wstrb} !== {a, d, s}) begin
        errors++; $display("FAIL rand%0d_wr_payload got %h want %h", n,
                           {cap_awaddr, cap_wdata, cap_wstrb}, {a, d, s});
      end else if (!w && cap_araddr !== a) begin
        errors++; $display("FAIL rand%0d_rd_addr got %h want %h", n, cap_araddr, a);
      end
      rsp_handshake($urandom_range(0, 2));
      checks++;
      if ({aw_n - aw0, w_n - w0, b_n - b0, ar_n - ar0, r_n - r0} !==
          (w ? {32'd1, 32'd1, 32'd1, 32'd0, 32'd0} : {32'd0, 32'd0, 32'd0, 32'd1, 32'd1})) begin
        errors++; $display("FAIL rand%0d_counts got %0d/%0d/%0d/%0d/%0d", n,
                           aw_n - aw0, w_n - w0, b_n - b0, ar_n - ar0, r_n - r0);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++; $display("FAIL rand%0d_cmd_ready got %b want 1", n, cmd_ready);
      end
    end
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
  endtask

`ifdef AXI4LITE_CMD_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, bad; int waited, k, b0;
    aw_delay = 0; w_delay = 0; b_en = 1'b0;
    b0 = b_n;
    issue(1'b1, 4'h6, 32'hDEAD_BEEF, 4'hF, ok, waited);
    wait_rsp(1, k);
    checks++;
    if (k !== TO + 1) begin errors++; $display("FAIL to_latency got %0d want %0d", k, TO + 1); end
    checks++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== {32'h0, 2'b10, 1'b1}) begin
      errors++; $display("FAIL to_rsp got %h want %h", {rsp_rdata, rsp_resp, rsp_timeout},
                         {32'h0, 2'b10, 1'b1});
    end
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
      errors++; $display("FAIL to_dropped got %b want 0", {awvalid, wvalid, arvalid, bready, rready});
    end
    rsp_handshake(0);
    b_en = 1'b1;  // late B from the slave
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || b_n !== b0 || bvalid !== 1'b1) begin
      errors++; $display("FAIL to_late_b got bready_seen=%0d b=%0d bvalid=%b want 0 %0d 1",
                         bad, b_n - b0, bvalid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_write_zero_wait();
    test_w_before_aw();
    test_read_wait();
    test_rsp_backpressure();
    test_reset_mid();
    test_random();
`ifdef AXI4LITE_CMD_MASTER_TIMEOUT_EN
    test_timeout();
    test_random();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
